// File: rtl/llsc_link_unit.sv
`default_nettype none
// ============================================================================
//  Module   : llsc_link_unit
//  Purpose  : Per-core load-linked / store-conditional responder sitting
//             between the MEM stage and the dcache. Holds the link register
//             armed by LL and resolves each SC as success (write forwarded,
//             1 returned) or failure (write suppressed, 0 returned).
//  Ports    : CLK, RST                    clock, sync active-high reset
//             dp_*                        datapath request / response
//             dc_*                        dcache request / response
//             snp_inv, snp_addr           coherence invalidation from others
//             link_valid                  link register valid (debug)
//  Revision : 1.0  initial release
// ============================================================================
module llsc_link_unit #(
    parameter int LINK_LSB = 2,   // own-core match granularity (word)
    parameter int SNP_LSB  = 3    // snoop match granularity (block); >= LINK_LSB
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dp_dmemREN,
    input  logic        dp_dmemWEN,
    input  logic        dp_llsc,
    input  logic [31:0] dp_dmemaddr,
    input  logic [31:0] dp_dmemstore,
    output logic        dp_dhit,
    output logic [31:0] dp_dmemload,
    output logic        dc_dmemREN,
    output logic        dc_dmemWEN,
    output logic [31:0] dc_dmemaddr,
    output logic [31:0] dc_dmemstore,
    input  logic        dc_dhit,
    input  logic [31:0] dc_dmemload,
    input  logic        snp_inv,
    input  logic [31:0] snp_addr,
    output logic        link_valid
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SC_WRITE = 2'd1,
        ST_SC_FAIL  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_link_valid;
    // Only the compared address bits are kept; bits below LINK_LSB never
    // take part in any match.
    logic [31:LINK_LSB]  r_link_word;

    logic w_is_sc;
    logic w_word_hit;
    logic w_snp_hit;
    logic w_unused_snp;

    assign w_is_sc    = dp_dmemWEN & dp_llsc;
    assign w_word_hit = (dp_dmemaddr[31:LINK_LSB] == r_link_word);
    assign w_snp_hit  = snp_inv & (snp_addr[31:SNP_LSB] == r_link_word[31:SNP_LSB]);
    assign w_unused_snp = ^snp_addr[SNP_LSB-1:0];

    assign link_valid = r_link_valid;

    // ------------------------------------------------------------------
    // Request steering. Everything is forced low while reset is held so
    // a pending request cannot leak through during reset.
    // ------------------------------------------------------------------
    always_comb begin
        dp_dhit      = 1'b0;
        dp_dmemload  = 32'd0;
        dc_dmemREN   = 1'b0;
        dc_dmemWEN   = 1'b0;
        dc_dmemaddr  = 32'd0;
        dc_dmemstore = 32'd0;
        if (!RST) begin
            case (r_state)
                ST_IDLE: begin
                    // An SC spends its first cycle deciding; nothing goes out.
                    if (!w_is_sc) begin
                        dc_dmemREN   = dp_dmemREN;
                        dc_dmemWEN   = dp_dmemWEN;
                        dc_dmemaddr  = dp_dmemaddr;
                        dc_dmemstore = dp_dmemstore;
                        dp_dhit      = dc_dhit;
                        dp_dmemload  = dc_dmemload;
                    end
                end
                ST_SC_WRITE: begin
                    // A matching snoop before the dcache commits aborts the
                    // write immediately; once dc_dhit is seen it is too late.
                    dc_dmemWEN   = ~w_snp_hit | dc_dhit;
                    dc_dmemaddr  = dp_dmemaddr;
                    dc_dmemstore = dp_dmemstore;
                    dp_dhit      = dc_dhit;
                    dp_dmemload  = {31'd0, dc_dhit};
                end
                ST_SC_FAIL: begin
                    dp_dhit = 1'b1;
                end
                default: begin
                    dp_dhit = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and link register.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_link_valid <= 1'b0;
            r_link_word  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_sc) begin
                        if (r_link_valid && w_word_hit && !w_snp_hit)
                            r_state <= ST_SC_WRITE;
                        else
                            r_state <= ST_SC_FAIL;
                    end else if (dp_dmemREN && dp_llsc && dc_dhit) begin
                        r_link_valid <= 1'b1;
                        r_link_word  <= dp_dmemaddr[31:LINK_LSB];
                    end else if (dp_dmemWEN && dc_dhit && w_word_hit) begin
                        r_link_valid <= 1'b0;
                    end
                end
                ST_SC_WRITE: begin
                    if (dc_dhit) begin
                        r_link_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (w_snp_hit) begin
                        r_state <= ST_SC_FAIL;
                    end
                end
                ST_SC_FAIL: begin
                    r_link_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Placed last so a matching snoop overrides any same-cycle LL.
            if (w_snp_hit)
                r_link_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_llsc_link_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_llsc_link_unit
//  Purpose  : Self-checking bench for llsc_link_unit: directed vector table,
//             reset sequences, and random operations against a
//             transaction-level link/memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_llsc_link_unit;

    localparam int K_LW  = 0;
    localparam int K_SW  = 1;
    localparam int K_LL  = 2;
    localparam int K_SC  = 3;
    localparam int K_SNP = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dp_dmemREN, dp_dmemWEN, dp_llsc;
    logic [31:0] dp_dmemaddr, dp_dmemstore;
    logic        dp_dhit;
    logic [31:0] dp_dmemload;
    logic        dc_dmemREN, dc_dmemWEN;
    logic [31:0] dc_dmemaddr, dc_dmemstore;
    logic        dc_dhit;
    logic [31:0] dc_dmemload;
    logic        snp_inv;
    logic [31:0] snp_addr;
    logic        link_valid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dc_mem  [0:1023];   // the emulated dcache contents
    logic [31:0] ref_mem [0:1023];   // the model's view of memory

    always #5 CLK = ~CLK;

    llsc_link_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .dp_dmemREN   (dp_dmemREN),
        .dp_dmemWEN   (dp_dmemWEN),
        .dp_llsc      (dp_llsc),
        .dp_dmemaddr  (dp_dmemaddr),
        .dp_dmemstore (dp_dmemstore),
        .dp_dhit      (dp_dhit),
        .dp_dmemload  (dp_dmemload),
        .dc_dmemREN   (dc_dmemREN),
        .dc_dmemWEN   (dc_dmemWEN),
        .dc_dmemaddr  (dc_dmemaddr),
        .dc_dmemstore (dc_dmemstore),
        .dc_dhit      (dc_dhit),
        .dc_dmemload  (dc_dmemload),
        .snp_inv      (snp_inv),
        .snp_addr     (snp_addr),
        .link_valid   (link_valid)
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          snp_c;
        logic [31:0] snp_a;
        bit          chk_res;
        logic [31:0] exp_res;
        int          exp_cyc;
        bit          exp_wen;
        bit          exp_link;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        dp_dmemREN   = 1'b0;
        dp_dmemWEN   = 1'b0;
        dp_llsc      = 1'b0;
        dp_dmemaddr  = 32'd0;
        dp_dmemstore = 32'd0;
    endtask

    task automatic set_req(input int kind, input logic [31:0] addr, input logic [31:0] data);
        dp_dmemREN   = (kind == K_LW) || (kind == K_LL);
        dp_dmemWEN   = (kind == K_SW) || (kind == K_SC);
        dp_llsc      = (kind == K_LL) || (kind == K_SC);
        dp_dmemaddr  = addr;
        dp_dmemstore = data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dp_dhit"},   {31'd0, dp_dhit},    32'd0);
        check({tag, "_dp_load"},   dp_dmemload,         32'd0);
        check({tag, "_dc_ren"},    {31'd0, dc_dmemREN}, 32'd0);
        check({tag, "_dc_wen"},    {31'd0, dc_dmemWEN}, 32'd0);
        check({tag, "_dc_addr"},   dc_dmemaddr,         32'd0);
        check({tag, "_dc_store"},  dc_dmemstore,        32'd0);
        check({tag, "_link"},      {31'd0, link_valid}, 32'd0);
    endtask

    // Presents one operation, acts as the dcache (responds after 'lat'
    // cycles of an outstanding request), optionally raises a snoop in cycle
    // snp_c after the dcache has answered, and waits for dp_dhit. Then one
    // idle cycle is spent to observe the updated link register.
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input int snp_c, input logic [31:0] snp_a,
                          output logic [31:0] res, output int cyc, output bit saw_wen,
                          output bit link_after);
        int cnt;
        bit done;
        cnt = 0; done = 0; res = 32'd0; cyc = -1; saw_wen = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (kind == K_SNP) set_idle();
            else set_req(kind, addr, data);
            snp_inv     = 1'b0;
            snp_addr    = snp_a;
            dc_dhit     = 1'b0;
            dc_dmemload = 32'd0;
            #1;
            if (dc_dmemREN || dc_dmemWEN) begin
                if (cnt == lat) begin
                    dc_dhit = 1'b1;
                    if (dc_dmemWEN) dc_mem[dc_dmemaddr[11:2]] = dc_dmemstore;
                    else            dc_dmemload = dc_mem[dc_dmemaddr[11:2]];
                end
                cnt++;
            end
            snp_inv = (c == snp_c);
            #1;
            if (dc_dmemWEN) saw_wen = 1;
            if (kind == K_SNP) begin
                done = 1; cyc = c;
            end else if (dp_dhit) begin
                done = 1; cyc = c; res = dp_dmemload;
            end
        end
        if (!done) check("op_timeout", 32'd0, 32'd1);
        @(negedge CLK);
        set_idle();
        snp_inv = 1'b0; dc_dhit = 1'b0; dc_dmemload = 32'd0;
        #1;
        link_after = link_valid;
    endtask

    initial begin
        logic [31:0] res;
        int          cyc;
        bit          wen;
        bit          lnk;
        logic [31:0] pool [5];
        bit          mv;
        logic [31:0] ma;

        for (int i = 0; i < 1024; i++) begin
            dc_mem[i]  = 32'd0;
            ref_mem[i] = 32'd0;
        end
        set_idle();
        snp_inv = 1'b0; snp_addr = 32'd0; dc_dhit = 1'b0; dc_dmemload = 32'd0;

        // ---------------- reset: outputs low even with a request held ----
        RST = 1'b1;
        set_req(K_LW, 32'h100, 32'h55);
        dc_dhit = 1'b1; dc_dmemload = 32'h1234;
        repeat (2) @(negedge CLK);
        #1;
        check_all_zero("in_reset");
        @(negedge CLK);
        RST = 1'b0;
        set_idle(); dc_dhit = 1'b0; dc_dmemload = 32'd0;
        #1;
        check_all_zero("after_reset");

        // ---------------- directed vector table ----------------
        //          kind   addr      data         lat snp_c snp_a    chk res           cyc wen link
        tbl[0]  = '{K_LL,  32'h100, 32'h0,        3, -1, 32'h0,   0, 32'h0,         3, 0, 1};
        tbl[1]  = '{K_SC,  32'h100, 32'hDEADBEEF, 2, -1, 32'h0,   1, 32'h1,         3, 1, 0};
        tbl[2]  = '{K_LW,  32'h100, 32'h0,        1, -1, 32'h0,   1, 32'hDEADBEEF,  1, 0, 0};
        tbl[3]  = '{K_LL,  32'h100, 32'h0,        0, -1, 32'h0,   0, 32'h0,         0, 0, 1};
        tbl[4]  = '{K_SNP, 32'h0,   32'h0,        0,  0, 32'h104, 0, 32'h0,         0, 0, 0};
        tbl[5]  = '{K_SC,  32'h100, 32'h1111,     0, -1, 32'h0,   1, 32'h0,         1, 0, 0};
        tbl[6]  = '{K_SC,  32'h40,  32'h2A2A,     0, -1, 32'h0,   1, 32'h0,         1, 0, 0};
        tbl[7]  = '{K_LL,  32'h100, 32'h0,        1, -1, 32'h0,   0, 32'h0,         1, 0, 1};
        tbl[8]  = '{K_SC,  32'h200, 32'h3B3B,     0, -1, 32'h0,   1, 32'h0,         1, 0, 0};
        tbl[9]  = '{K_LL,  32'h100, 32'h0,        0, -1, 32'h0,   0, 32'h0,         0, 0, 1};
        tbl[10] = '{K_SW,  32'h100, 32'h2222,     2, -1, 32'h0,   0, 32'h0,         2, 1, 0};
        tbl[11] = '{K_SC,  32'h100, 32'h3333,     0, -1, 32'h0,   1, 32'h0,         1, 0, 0};
        tbl[12] = '{K_LW,  32'h100, 32'h0,        0, -1, 32'h0,   1, 32'h2222,      0, 0, 0};
        tbl[13] = '{K_LL,  32'h100, 32'h0,        0, -1, 32'h0,   1, 32'h2222,      0, 0, 1};
        tbl[14] = '{K_SW,  32'h108, 32'h4444,     1, -1, 32'h0,   0, 32'h0,         1, 1, 1};
        tbl[15] = '{K_SC,  32'h100, 32'h5555,     0, -1, 32'h0,   1, 32'h1,         1, 1, 0};
        tbl[16] = '{K_LL,  32'h100, 32'h0,        0, -1, 32'h0,   1, 32'h5555,      0, 0, 1};
        tbl[17] = '{K_SC,  32'h100, 32'h6666,     3,  2, 32'h100, 1, 32'h0,         3, 1, 0};
        tbl[18] = '{K_LW,  32'h100, 32'h0,        0, -1, 32'h0,   1, 32'h5555,      0, 0, 0};
        tbl[19] = '{K_LL,  32'h100, 32'h0,        0, -1, 32'h0,   0, 32'h0,         0, 0, 1};
        tbl[20] = '{K_SC,  32'h100, 32'h7777,     2,  3, 32'h100, 1, 32'h1,         3, 1, 0};
        tbl[21] = '{K_LW,  32'h100, 32'h0,        0, -1, 32'h0,   1, 32'h7777,      0, 0, 0};

        for (int i = 0; i < 22; i++) begin
            run_op(tbl[i].kind, tbl[i].addr, tbl[i].data, tbl[i].lat,
                   tbl[i].snp_c, tbl[i].snp_a, res, cyc, wen, lnk);
            if (tbl[i].chk_res) check($sformatf("vec%0d_result", i), res, tbl[i].exp_res);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
            check($sformatf("vec%0d_dc_wen", i), {31'd0, wen}, {31'd0, tbl[i].exp_wen});
            check($sformatf("vec%0d_link", i), {31'd0, lnk}, {31'd0, tbl[i].exp_link});
        end

        // ---------------- reset in the middle of an SC write ----------------
        run_op(K_LL, 32'h100, 32'h0, 0, -1, 32'h0, res, cyc, wen, lnk);
        check("rst_seq_ll_link", {31'd0, lnk}, 32'd1);
        @(negedge CLK);
        set_req(K_SC, 32'h100, 32'hABCD0123);
        #1;
        check("rst_seq_decide_wen", {31'd0, dc_dmemWEN}, 32'd0);
        check("rst_seq_decide_dhit", {31'd0, dp_dhit}, 32'd0);
        @(negedge CLK);
        #1;
        check("rst_seq_scwrite_wen", {31'd0, dc_dmemWEN}, 32'd1);
        check("rst_seq_scwrite_store", dc_dmemstore, 32'hABCD0123);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_seq_held_wen", {31'd0, dc_dmemWEN}, 32'd0);
        check("rst_seq_held_dhit", {31'd0, dp_dhit}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        set_idle();
        #1;
        check_all_zero("rst_seq_after");
        run_op(K_SC, 32'h100, 32'h99, 0, -1, 32'h0, res, cyc, wen, lnk);
        check("rst_seq_sc_result", res, 32'd0);
        check("rst_seq_sc_cycles", 32'(cyc), 32'd1);
        check("rst_seq_sc_wen", {31'd0, wen}, 32'd0);
        // The aborted write must not have reached memory.
        run_op(K_LW, 32'h100, 32'h0, 0, -1, 32'h0, res, cyc, wen, lnk);
        check("rst_seq_mem_intact", res, 32'h7777);

        // ---------------- random operations vs. reference model ----------------
        for (int i = 0; i < 1024; i++) ref_mem[i] = dc_mem[i];
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108;
        pool[3] = 32'h10C; pool[4] = 32'h200;
        mv = 0; ma = 32'd0;
        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [31:0] a, d;
            int          lat;
            logic [31:0] e_res;
            int          e_cyc;
            bit          e_wen;
            bit          chk;
            kind = $urandom_range(0, 4);
            a    = pool[$urandom_range(0, 4)];
            d    = $urandom;
            lat  = $urandom_range(0, 3);
            chk  = 1; e_res = 32'd0; e_cyc = lat; e_wen = 0;
            case (kind)
                K_LW: e_res = ref_mem[a[11:2]];
                K_SW: begin
                    chk = 0; e_wen = 1;
                    ref_mem[a[11:2]] = d;
                    if (mv && (ma >> 2) == (a >> 2)) mv = 0;
                end
                K_LL: begin
                    e_res = ref_mem[a[11:2]];
                    mv = 1; ma = a;
                end
                K_SC: begin
                    if (mv && (ma >> 2) == (a >> 2)) begin
                        e_res = 32'd1; e_cyc = 1 + lat; e_wen = 1;
                        ref_mem[a[11:2]] = d;
                    end else begin
                        e_res = 32'd0; e_cyc = 1;
                    end
                    mv = 0;
                end
                default: begin
                    chk = 0; e_cyc = 0;
                    if (mv && (ma >> 3) == (a >> 3)) mv = 0;
                end
            endcase
            run_op(kind, a, d, lat, (kind == K_SNP) ? 0 : -1, a, res, cyc, wen, lnk);
            if (chk) check($sformatf("rnd%0d_k%0d_result", n, kind), res, e_res);
            check($sformatf("rnd%0d_k%0d_cycles", n, kind), 32'(cyc), 32'(e_cyc));
            check($sformatf("rnd%0d_k%0d_dc_wen", n, kind), {31'd0, wen}, {31'd0, e_wen});
            check($sformatf("rnd%0d_k%0d_link", n, kind), {31'd0, lnk}, {31'd0, mv});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
